// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: sequences a parallel operand pair through a bit-serial adder core and reassembles the sum.
// Optional: define SERIAL_ADD_CTRL_OVF_EN to add a registered two's-complement overflow output (ovf).
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ser_a,
    output logic             ser_b,
    output logic             ser_clr,
    output logic             ser_en,
    input  logic             ser_s,
    input  logic             ser_co,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_CTRL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [CW-1:0]    cnt;

    // The core sees the current LSB of the internal operand copies.
    assign ser_a = a_reg[0];
    assign ser_b = b_reg[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            cnt     <= '0;
            ser_clr <= 1'b0;
            ser_en  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
`ifdef SERIAL_ADD_CTRL_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= LOAD;
                        a_reg   <= A;
                        b_reg   <= B;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        ser_clr <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                LOAD: begin
                    state   <= SHIFT;
                    ser_clr <= 1'b0;
                    ser_en  <= 1'b1;
                end
                SHIFT: begin
                    sum[cnt] <= ser_s;
                    a_reg    <= a_reg >> 1;
                    b_reg    <= b_reg >> 1;
                    cnt      <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state  <= DONE;
                        cout   <= ser_co;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        ser_en <= 1'b0;
`ifdef SERIAL_ADD_CTRL_OVF_EN
                        // On the last bit the operand LSBs are the captured MSBs and ser_s is the sum MSB.
                        ovf    <= (a_reg[0] == b_reg[0]) && (ser_s != a_reg[0]);
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=4 and WIDTH=8 instances, each with a behavioural adder core).
module tb_serial_add_ctrl;

    localparam int unsigned W  = 4;
    localparam int unsigned W8 = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  a_in = '0;
    logic [W-1:0]  b_in = '0;
    logic          ser_a, ser_b, ser_clr, ser_en, ser_s, ser_co, busy, done, cout;
    logic [W-1:0]  sum;

    logic          start8 = 1'b0;
    logic [W8-1:0] a8 = '0;
    logic [W8-1:0] b8 = '0;
    logic          ser_a8, ser_b8, ser_clr8, ser_en8, ser_s8, ser_co8, busy8, done8, cout8;
    logic [W8-1:0] sum8;

    logic [W+1:0]  got4;
    logic [W8+1:0] got8;
`ifdef SERIAL_ADD_CTRL_OVF_EN
    logic ovf, ovf8;
    assign got4 = {ovf, cout, sum};
    assign got8 = {ovf8, cout8, sum8};
`else
    assign got4 = {1'b0, cout, sum};
    assign got8 = {1'b0, cout8, sum8};
`endif

    int total = 0;
    int bad   = 0;
    int n_done = 0;
    int n_clr  = 0;
    int cyc    = 0;
    logic [W+1:0]  exp_q[$];
    logic [W8+1:0] exp8_q[$];

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .A(a_in), .B(b_in),
        .ser_a(ser_a), .ser_b(ser_b), .ser_clr(ser_clr), .ser_en(ser_en),
        .ser_s(ser_s), .ser_co(ser_co), .busy(busy), .done(done),
        .sum(sum), .cout(cout)
`ifdef SERIAL_ADD_CTRL_OVF_EN
        , .ovf(ovf)
`endif
    );

    serial_add_ctrl #(.WIDTH(W8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .A(a8), .B(b8),
        .ser_a(ser_a8), .ser_b(ser_b8), .ser_clr(ser_clr8), .ser_en(ser_en8),
        .ser_s(ser_s8), .ser_co(ser_co8), .busy(busy8), .done(done8),
        .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADD_CTRL_OVF_EN
        , .ovf(ovf8)
`endif
    );

    // Behavioural 1-bit adder cores: carry register with clear and enable.
    logic carry = 1'b0, carry8 = 1'b0;
    assign ser_s   = ser_a ^ ser_b ^ carry;
    assign ser_co  = (ser_a & ser_b) | (ser_a & carry) | (ser_b & carry);
    assign ser_s8  = ser_a8 ^ ser_b8 ^ carry8;
    assign ser_co8 = (ser_a8 & ser_b8) | (ser_a8 & carry8) | (ser_b8 & carry8);
    always @(posedge clk) begin
        if (ser_clr) carry <= 1'b0;
        else if (ser_en) carry <= ser_co;
        if (ser_clr8) carry8 <= 1'b0;
        else if (ser_en8) carry8 <= ser_co8;
        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W+1:0] model4(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] s;
        logic v;
        s = {1'b0, x} + {1'b0, y};
`ifdef SERIAL_ADD_CTRL_OVF_EN
        v = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
`else
        v = 1'b0;
`endif
        return {v, s};
    endfunction

    function automatic logic [W8+1:0] model8(input logic [W8-1:0] x, input logic [W8-1:0] y);
        logic [W8:0] s;
        logic v;
        s = {1'b0, x} + {1'b0, y};
`ifdef SERIAL_ADD_CTRL_OVF_EN
        v = (x[W8-1] == y[W8-1]) && (s[W8-1] != x[W8-1]);
`else
        v = 1'b0;
`endif
        return {v, s};
    endfunction

    // Scoreboard monitors: pop the oldest expectation on every done pulse.
    always @(negedge clk) begin
        if (ser_clr) n_clr++;
        if (done) begin
            n_done++;
            check("sb4_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("result4", 32'(got4), 32'(exp_q.pop_front()));
        end
        if (done8) begin
            check("sb8_nonempty", 32'(exp8_q.size() != 0), 32'd1);
            if (exp8_q.size() != 0) check("result8", 32'(got8), 32'(exp8_q.pop_front()));
        end
    end

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
        start = 1'b1;
        a_in  = x;
        b_in  = y;
        if (push) exp_q.push_back(model4(x, y));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int at);
        bit seen;
        seen = 1'b0;
        at = -1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                at = cyc;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic run_trace(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W+1:0] e;
        e = model4(x, y);
        issue(x, y, 1'b1);
        check("load_clr", 32'(ser_clr), 32'd1);
        check("load_en", 32'(ser_en), 32'd0);
        check("load_busy", 32'(busy), 32'd1);
        for (int i = 0; i < W; i++) begin
            @(posedge clk); #1;
            check("shift_en", 32'(ser_en), 32'd1);
            check("shift_clr", 32'(ser_clr), 32'd0);
            check("shift_busy", 32'(busy), 32'd1);
            check("ser_a", 32'(ser_a), 32'(x[i]));
            check("ser_b", 32'(ser_b), 32'(y[i]));
        end
        @(posedge clk); #1;
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("done_en", 32'(ser_en), 32'd0);
        check("trace_sum", 32'(sum), 32'(e[W-1:0]));
        check("trace_cout", 32'(cout), 32'(e[W]));
        @(posedge clk); #1;
        check("done_once", 32'(done), 32'd0);
    endtask

    initial begin
        int t1, t2, t3, t4, nd, nc;
        logic [W+1:0] e;

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ser", 32'({ser_a, ser_b, ser_clr, ser_en}), 32'd0);
`ifdef SERIAL_ADD_CTRL_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif

        // Directed traces
        run_trace(W'(5), W'(3));
        run_trace(W'(15), W'(1));
        e = model4(W'(15), W'(1));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_result", 32'(got4), 32'(e));
        end

        // start held high: back-to-back operations every W+2 cycles
        nc = n_clr;
        for (int i = 0; i < 4; i++) exp_q.push_back(model4(W'(2), W'(2)));
        start = 1'b1; a_in = W'(2); b_in = W'(2);
        wait_done(t1);
        wait_done(t2);
        wait_done(t3);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(t4);
        check("period12", 32'(t2 - t1), 32'(W + 2));
        check("period23", 32'(t3 - t2), 32'(W + 2));
        check("period34", 32'(t4 - t3), 32'(W + 2));
        check("clr_per_op", 32'(n_clr - nc), 32'd4);

        // start and operand changes during SHIFT are ignored
        @(posedge clk); #1;
        nd = n_done;
        issue(W'(6), W'(5), 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1; a_in = W'(15); b_in = W'(15);
        @(posedge clk); #1;
        start = 1'b0; a_in = '0; b_in = '0;
        wait_done(t1);
        repeat (10) @(negedge clk);
        check("single_done", 32'(n_done - nd), 32'd1);

        // reset on the 2nd SHIFT cycle discards the operation
        @(posedge clk); #1;
        issue(W'(7), W'(6), 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_en", 32'(ser_en), 32'd0);
        nd = n_done;
        repeat (10) @(negedge clk);
        check("midrst_no_done", 32'(n_done - nd), 32'd0);
        @(posedge clk); #1;
        issue(W'(9), W'(4), 1'b1);
        wait_done(t1);

        // Random operands, WIDTH=4 (back-to-back from DONE)
        for (int k = 0; k < 1000; k++) begin
            issue(W'($urandom), W'($urandom), 1'b1);
            wait_done(t1);
        end

        // Random operands, WIDTH=8
        @(posedge clk); #1;
        for (int k = 0; k < 1000; k++) begin
            bit seen;
            start8 = 1'b1;
            a8 = W8'($urandom);
            b8 = W8'($urandom);
            exp8_q.push_back(model8(a8, b8));
            @(posedge clk); #1;
            start8 = 1'b0;
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge clk);
                if (done8) seen = 1'b1;
            end
            check("done8_seen", 32'(seen), 32'd1);
            @(posedge clk); #1;
        end

        repeat (5) @(negedge clk);
        check("sb_drained", 32'(exp_q.size() + exp8_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Sequencing controller for the bit-serial adder core. Accepts a parallel operand pair on a start pulse, clears the core's carry state, and streams both operands LSB-first into the core for WIDTH cycles. It then reassembles the serial sum bits into a parallel result with carry-out and signals completion with a one-cycle done pulse. It sits between the parallel register file/bus side and the 1-bit adder FSM.

## Interface
- WIDTH, 4, operand/result width in bits (≥2).
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- A  in  WIDTH  operand A, captured on accepted start.
- B  in  WIDTH  operand B, captured on accepted start.
- ser_a  out  1  current A bit to the adder core.
- ser_b  out  1  current B bit to the adder core.
- ser_clr  out  1  synchronous clear of the core carry state.
- ser_en  out  1  core carry-state update enable.
- ser_s  in  1  core combinational sum bit for the current ser_a/ser_b and carry.
- ser_co  in  1  core combinational carry-out for the current bit.
- busy  out  1  high in LOAD and SHIFT.
- done  out  1  one-cycle completion pulse.
- sum  out  WIDTH  parallel result; held until the next accepted start.
- cout  out  1  final carry-out; held with sum.

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: start=1 → capture A, B into internal shift registers, clear the bit counter, go to LOAD. start=0 → stay.
- LOAD: ser_clr=1, ser_en=0 for exactly one cycle, then go to SHIFT.
- SHIFT: ser_en=1. ser_a/ser_b = bit[i] of the captured operands, with i = 0..WIDTH-1, LSB first.
  - Each cycle: ser_s is shifted into the result register at position i, and both operand registers shift right.
  - Counter i == WIDTH-1 → also capture ser_co into cout, then go to DONE.
- DONE: done=1 for one cycle. start=1 → accepted exactly as in IDLE (back-to-back operation, goes to LOAD); otherwise go to IDLE.
- start in LOAD/SHIFT is ignored; it is not queued.
- The operand registers are internal copies: A/B may change freely after acceptance without affecting the result.
- Arithmetic: {cout, sum} = A + B, unsigned, modulo 2^(WIDTH+1).
- sum and cout are updated only in SHIFT. The result register bits shift in progressively, so sum is valid only from the done cycle onward.
- ser_a, ser_b, ser_clr, ser_en are 0 outside their stated states.

## Timing
- Reset (any state, including mid-SHIFT): next state is IDLE. busy, done, ser_* go to 0; sum and cout go to 0; counter and operand registers go to 0. The in-flight operation is discarded.
- Start sampled at edge E0 → LOAD during cycle after E0 → SHIFT cycles after E1..E_WIDTH → done high in the cycle after E(WIDTH+1).
- Latency from the accepting edge to done: WIDTH+1 edges. Throughput with start held continuously: one result per WIDTH+2 cycles.
- busy falls in the same cycle done rises.
- All outputs are registered except ser_a/ser_b, which are driven from the LSB of the operand registers.

## Configuration
- SERIAL_ADD_CTRL_OVF_EN defined: adds output ovf (out, 1).
  - ovf is the two's-complement overflow, equal to (A[MSB]==B[MSB]) && (sum[MSB]!=A[MSB]) using the captured operands.
  - It is registered at the transition to DONE, held with sum, and reset to 0.
- Macro undefined: no ovf port and no related logic. All other behaviour is identical.

## Test plan
- Reset, then start with A=0101, B=0011 (WIDTH=4) → ser_clr high 1 cycle, 4 SHIFT cycles with ser_a=1,0,1,0 and ser_b=1,1,0,0; done pulses after E5; sum=1000, cout=0; with OVF_EN, ovf=1.
- A=1111, B=0001 → sum=0000, cout=1, ovf=0; sum/cout remain stable over 10 idle cycles.
- start held high continuously with A=0010, B=0010 → done every 6 cycles, sum=0100 each time, ser_clr asserted before every operation.
- start pulsed and A/B changed during SHIFT → the extra start is ignored, the result uses the originally captured operands, and only one done pulse occurs.
- reset asserted on the 2nd SHIFT cycle → next cycle IDLE with busy=0, done=0, sum=0; no done pulse follows; a new start completes correctly.
- Random operands, 1000 iterations, WIDTH=4 and WIDTH=8 → {cout,sum} == A+B every time.
